// File: rtl/projectile_pkg.sv
// Types and geometry helpers for the projectile integrator.
package projectile_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, FLIGHT, RESULT} state_t;
  typedef enum logic [1:0] {
    RES_NONE       = 2'd0,
    RES_TARGET     = 2'd1,
    RES_WALL       = 2'd2,
    RES_GROUND_OUT = 2'd3
  } result_t;

  localparam int INT_MAX = 32'h7fff_ffff;

  function automatic logic inside_rect(input int px, py, x0, x1, y0, y1);
    return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
  endfunction
endpackage

// File: rtl/vga_pkg.sv
// Screen geometry shared by the video pipeline and anything that draws into it.
package vga_pkg;
  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
endpackage

// File: rtl/projectile_ctl_if.sv
// Game-logic <-> projectile integrator handshake: throw request in, sprite position and result out.
interface projectile_ctl_if #(
  parameter int POS_W   = 12,
  parameter int FORCE_W = 10
);
  import projectile_pkg::*;

  logic                      launch;
  logic                      abort;
  logic        [FORCE_W-1:0] throw_force;
  logic signed [7:0]         wind;
  logic signed [POS_W-1:0]   x_pos;
  logic signed [POS_W-1:0]   y_pos;
  logic                      busy;
  logic                      done;
  result_t                   result;

  modport master (
    output launch, abort, throw_force, wind,
    input  x_pos, y_pos, busy, done, result
  );
  modport slave (
    input  launch, abort, throw_force, wind,
    output x_pos, y_pos, busy, done, result
  );
endinterface

// File: rtl/projectile_ctl_tick_gen.sv
// Free-running physics tick divider: one-cycle strobe every TICK_DIV clocks, cleared only by rst.
module tick_gen #(
  parameter int TICK_DIV = 1_300_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CW'(TICK_DIV - 1)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CW'(TICK_DIV - 1));
endmodule

// File: rtl/projectile_ctl.sv
// Fixed-point Euler projectile integrator: launch, per-tick motion, collision classification.
module projectile_ctl
  import projectile_pkg::*;
  import vga_pkg::*;
#(
  parameter int TICK_DIV  = 1_300_000,
  parameter int POS_W     = 12,
  parameter int FRAC_BITS = 4,
  parameter int FORCE_W   = 10,
  parameter int FORCE_K   = 18,
  parameter int VY0       = 27,
  parameter int GRAVITY   = 1,
  parameter int START_X   = 140,
  parameter int START_Y   = 350,
  parameter int GROUND_Y  = 600,
  parameter int WALL_X0   = 490,
  parameter int WALL_X1   = 534,
  parameter int WALL_Y0   = 241,
  parameter int TGT_X0    = 860,
  parameter int TGT_X1    = 1000,
  parameter int TGT_Y0    = 427,
  parameter int TGT_Y1    = 525,
  parameter int MAX_TICKS = 1023
) (
  input  logic             clk,
  input  logic             rst,
  projectile_ctl_if.slave  bus
);
  localparam int PW     = POS_W + FRAC_BITS + 2;
  localparam int VW     = POS_W + FRAC_BITS;
  localparam int PROD_W = FORCE_W + 7 + 8 + FRAC_BITS;
  localparam int CNT_W  = $clog2(MAX_TICKS + 1);
  localparam int ONE    = 1 << FRAC_BITS;

  localparam logic signed [PW-1:0] START_X_FP = PW'(START_X * ONE);
  localparam logic signed [PW-1:0] START_Y_FP = PW'(START_Y * ONE);
  localparam logic signed [PW-1:0] WALL_CL_FP = PW'((WALL_X0 - 1) * ONE);
  localparam logic signed [PW-1:0] GROUND_FP  = PW'(GROUND_Y * ONE);
  localparam logic signed [VW-1:0] VY0_FP     = VW'(VY0 * ONE);
  localparam logic signed [VW-1:0] GRAV_FP    = VW'(GRAVITY * ONE);

  function automatic logic signed [7:0] clamp_wind(input logic signed [7:0] w);
    if (w > 8'sd50)  return 8'sd50;
    if (w < -8'sd50) return -8'sd50;
    return w;
  endfunction

  function automatic int to_px(input logic signed [PW-1:0] p);
    return int'(p >>> FRAC_BITS);
  endfunction

  state_t                  state_q, state_d;
  result_t                 result_q, result_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic signed [PW-1:0]    x_q, x_d, y_q, y_d, x_step, y_step;
  logic signed [VW-1:0]    vx_q, vx_d, vy_q, vy_d, vx_launch;
  logic        [CNT_W-1:0] cnt_q, cnt_d, cnt_step;
  logic signed [7:0]       wind_c;
  logic        [PROD_W-1:0] prod;
  logic                    tick;
  int                      px, py;
  logic                    hit_tgt, hit_wall, hit_gnd, hit_out;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

  // Launch speed: percent wind scales force*K/100, all in fixed point.
  assign wind_c    = clamp_wind(bus.wind);
  assign prod      = (PROD_W'(bus.throw_force) * PROD_W'(FORCE_K)
                      * PROD_W'(100 + int'(wind_c))) << FRAC_BITS;
  assign vx_launch = VW'(prod / PROD_W'(10000));

  // Candidate position for this tick; collisions are judged on it, not on the held one.
  assign x_step   = x_q + $signed({{2{vx_q[VW-1]}}, vx_q});
  assign y_step   = y_q - $signed({{2{vy_q[VW-1]}}, vy_q});
  assign cnt_step = cnt_q + CNT_W'(1);
  assign px       = to_px(x_step);
  assign py       = to_px(y_step);
  assign hit_tgt  = inside_rect(px, py, TGT_X0, TGT_X1, TGT_Y0, TGT_Y1);
  assign hit_wall = inside_rect(px, py, WALL_X0, WALL_X1, WALL_Y0, INT_MAX);
  assign hit_gnd  = (py >= GROUND_Y);
  assign hit_out  = (px > HOR_PIXELS - 1) || (cnt_step == CNT_W'(MAX_TICKS));

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    cnt_d    = cnt_q;
    if (bus.abort) begin
      state_d  = IDLE;
      result_d = RES_NONE;
      busy_d   = 1'b0;
      x_d      = START_X_FP;
      y_d      = START_Y_FP;
      vx_d     = '0;
      vy_d     = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          x_d  = START_X_FP;
          y_d  = START_Y_FP;
          vx_d = '0;
          vy_d = '0;
          if (bus.launch) begin
            state_d  = LAUNCH;
            result_d = RES_NONE;
            busy_d   = 1'b1;
          end
        end
        LAUNCH: begin
          vx_d    = vx_launch;
          vy_d    = VY0_FP;
          x_d     = START_X_FP;
          y_d     = START_Y_FP;
          cnt_d   = '0;
          state_d = FLIGHT;
        end
        FLIGHT: begin
          if (tick) begin
            x_d   = x_step;
            y_d   = y_step;
            vy_d  = vy_q - GRAV_FP;
            cnt_d = cnt_step;
            if (hit_tgt) begin
              result_d = RES_TARGET;
            end else if (hit_wall) begin
              result_d = RES_WALL;
              x_d      = WALL_CL_FP;
            end else if (hit_gnd) begin
              result_d = RES_GROUND_OUT;
              y_d      = GROUND_FP;
            end else if (hit_out) begin
              result_d = RES_GROUND_OUT;
            end
            if (hit_tgt || hit_wall || hit_gnd || hit_out) begin
              state_d = RESULT;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        RESULT: begin
          if (!bus.launch) begin
            state_d = IDLE;
            x_d     = START_X_FP;
            y_d     = START_Y_FP;
            vx_d    = '0;
            vy_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= RES_NONE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= START_X_FP;
      y_q      <= START_Y_FP;
      vx_q     <= '0;
      vy_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.x_pos  = POS_W'(x_q >>> FRAC_BITS);
  assign bus.y_pos  = POS_W'(y_q >>> FRAC_BITS);
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_projectile_ctl.sv
// Bench for projectile_ctl at TICK_DIV=4: throw table with a result scoreboard plus
// hand sequences for first-tick latency, abort, relaunch and asynchronous reset.
module tb_projectile_ctl;
  import projectile_pkg::*;

  typedef struct {
    int frc;
    int wind;
    int res;
    int x;
    int y;
    int ticks;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[10];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  projectile_ctl_if #(.POS_W(12), .FORCE_W(10)) bus ();

  projectile_ctl #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    ok = (bus.done === 1'b1);
  endtask

  // Flight of N ticks ends N-th tick after entry; first tick lands 2..5 edges after launch edge.
  task automatic check_done(input string tag, input vec_t e, input int cyc, input bit ok);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done: no done after %0d cycles, required within %0d", tag, cyc, 4*e.ticks+1);
    end else begin
      check($sformatf("%s_result", tag), int'(bus.result), e.res);
      check($sformatf("%s_x", tag), int'(bus.x_pos), e.x);
      check($sformatf("%s_y", tag), int'(bus.y_pos), e.y);
      check_range($sformatf("%s_cycles", tag), cyc, 4*e.ticks-2, 4*e.ticks+1);
    end
  endtask

  task automatic launch_vec(input vec_t v, input string tag);
    @(negedge clk);
    bus.throw_force = 10'(v.frc);
    bus.wind        = 8'(v.wind);
    bus.launch      = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    check($sformatf("%s_busy", tag), int'(bus.busy), 1);
    check($sformatf("%s_res_clr", tag), int'(bus.result), 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   cyc;
    bit   ok;
    vec_t e;
    launch_vec(v, tag);
    wait_done(cyc, ok);
    e = exp_q.pop_front();
    check_done(tag, e, cyc, ok);
    if (ok) begin
      @(negedge clk);
      check($sformatf("%s_pulse", tag), int'(bus.done), 0);
      check($sformatf("%s_frozen_x", tag), int'(bus.x_pos), e.x);
      check($sformatf("%s_idle_busy", tag), int'(bus.busy), 0);
      bus.launch = 1'b0;
      @(negedge clk);
      check($sformatf("%s_home_x", tag), int'(bus.x_pos), 140);
      check($sformatf("%s_home_y", tag), int'(bus.y_pos), 350);
      check($sformatf("%s_res_kept", tag), int'(bus.result), e.res);
    end else begin
      bus.launch = 1'b0;
      bus.abort  = 1'b1;
      @(negedge clk);
      bus.abort  = 1'b0;
    end
  endtask

  initial begin
    int   cyc;
    bit   ok;
    bit   seen;
    vec_t e;

    //          force wind res  x     y    ticks
    vecs[0] = '{0,    0,   3,  140,  600, 63};
    vecs[1] = '{500,  0,   2,  489,  248, 4};
    vecs[2] = '{500,  80,  3,  1085, 182, 7};
    vecs[3] = '{72,   0,   1,  890,  437, 58};
    vecs[4] = '{100, -128, 3,  707,  600, 63};
    vecs[5] = '{300, -20,  3,  1046, -7,  21};
    vecs[6] = '{200,  10,  3,  1049, -18, 23};
    vecs[7] = '{400,  0,   3,  1076, 77,  13};
    vecs[8] = '{600, -10,  2,  489,  248, 4};
    vecs[9] = '{1023, 50,  3,  1244, 248, 4};

    rst             = 1'b1;
    bus.launch      = 1'b0;
    bus.abort       = 1'b0;
    bus.throw_force = '0;
    bus.wind        = '0;
    repeat (3) @(negedge clk);
    check("rst_x", int'(bus.x_pos), 140);
    check("rst_y", int'(bus.y_pos), 350);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_result", int'(bus.result), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);

    // First tick moves by exactly one step, then abort mid-flight.
    bus.throw_force = 10'd500;
    bus.wind        = 8'sd0;
    bus.launch      = 1'b1;
    @(negedge clk);
    check("ft_busy", int'(bus.busy), 1);
    cyc = 0;
    while (bus.x_pos == 12'sd140 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check("ft_x", int'(bus.x_pos), 230);
    check("ft_y", int'(bus.y_pos), 323);
    check_range("ft_latency", cyc, 2, 5);
    bus.abort  = 1'b1;
    bus.launch = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    check("ab_busy", int'(bus.busy), 0);
    check("ab_x", int'(bus.x_pos), 140);
    check("ab_y", int'(bus.y_pos), 350);
    check("ab_result", int'(bus.result), 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("ab_no_done", int'(seen), 0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Launch held through RESULT, one-cycle drop re-arms, then abort out of RESULT.
    launch_vec(vecs[1], "rl1");
    wait_done(cyc, ok);
    e = exp_q.pop_front();
    check_done("rl1", e, cyc, ok);
    repeat (3) @(negedge clk);
    check("rl_hold_busy", int'(bus.busy), 0);
    check("rl_hold_x", int'(bus.x_pos), 489);
    check("rl_hold_res", int'(bus.result), 2);
    bus.launch = 1'b0;
    @(negedge clk);
    check("rl_idle_x", int'(bus.x_pos), 140);
    check("rl_idle_y", int'(bus.y_pos), 350);
    check("rl_idle_res", int'(bus.result), 2);
    bus.launch = 1'b1;
    exp_q.push_back(vecs[1]);
    @(negedge clk);
    check("rl2_busy", int'(bus.busy), 1);
    check("rl2_res_clr", int'(bus.result), 0);
    wait_done(cyc, ok);
    e = exp_q.pop_front();
    check_done("rl2", e, cyc, ok);
    bus.abort  = 1'b1;
    bus.launch = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    check("rs_ab_res", int'(bus.result), 0);
    check("rs_ab_x", int'(bus.x_pos), 140);
    check("rs_ab_done", int'(bus.done), 0);

    // Asynchronous reset between clock edges during flight.
    @(negedge clk);
    bus.throw_force = 10'd500;
    bus.wind        = 8'sd80;
    bus.launch      = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("rm_busy", int'(bus.busy), 1);
    check("rm_moved", int'(bus.x_pos != 12'sd140), 1);
    #2;
    rst        = 1'b1;
    bus.launch = 1'b0;
    #1;
    check("rm_x", int'(bus.x_pos), 140);
    check("rm_y", int'(bus.y_pos), 350);
    check("rm_busy0", int'(bus.busy), 0);
    check("rm_done", int'(bus.done), 0);
    check("rm_result", int'(bus.result), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rm_idle_busy", int'(bus.busy), 0);
    run_vec(vecs[8], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
